des_arbiter: RTL

Round-robin front-end that shares one pipelined `des` core between two requesters. It accepts blocks over valid/ready handshakes, issues at most one block per cycle to the core, and records the owner of every in-flight block in a tag FIFO. It then steers each core result back to the requester that issued it. The block sits between the bus-side request logic and the `des` core and is the only driver of the core's inputs.

---
 rtl/des_pkg.sv | 16 +
 rtl/des_tag_fifo.sv | 74 +++++++
 rtl/des_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared types and widths for the DES arbiter front-end and its tag FIFO.
// Imported by des_tag_fifo and des_arbiter.
package des_pkg;

  localparam int DES_BLOCK_W = 64;
  localparam int DES_KEY_W   = 64;

  typedef enum logic {
    ST_DRAIN,
    ST_RUN
  } arb_state_e;

  // Owner of an in-flight block: 0 = requester 0, 1 = requester 1.
  typedef logic req_tag_t;

endpackage

// File: rtl/des_tag_fifo.sv
// In-order FIFO of 1-bit requester tags with occupancy count.
// Simultaneous push and pop is honoured when full or empty.
module des_tag_fifo
  import des_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  req_tag_t                   i_push_tag,
  input  logic                       i_pop,
  output req_tag_t                   o_pop_tag,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty   = (cnt_q == '0);
  assign o_full    = (cnt_q == CW'(DEPTH));
  assign o_count   = cnt_q;
  // Empty with a same-cycle push hands the new tag straight through.
  assign o_pop_tag = o_empty ? i_push_tag : mem_q[rd_q];

  always_comb begin
    push_ok = i_push & (~o_full | i_pop);
    pop_ok  = i_pop & (~o_empty | i_push);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = i_push_tag;
      wr_d        = ptr_inc(wr_q);
    end
    if (pop_ok) begin
      rd_d = ptr_inc(rd_q);
    end
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/des_arbiter.sv
// Round-robin front-end sharing one pipelined DES core between two requesters.
// Optional sticky protocol checker enabled by DES_ARB_CHECK_EN.
module des_arbiter
  import des_pkg::*;
#(
  parameter int CORE_LATENCY = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req0_valid,
  output logic                   o_req0_ready,
  input  logic [DES_BLOCK_W-1:0] i_req0_data,
  input  logic [DES_KEY_W-1:0]   i_req0_key,
  input  logic                   i_req0_encrypt,
  input  logic                   i_req1_valid,
  output logic                   o_req1_ready,
  input  logic [DES_BLOCK_W-1:0] i_req1_data,
  input  logic [DES_KEY_W-1:0]   i_req1_key,
  input  logic                   i_req1_encrypt,
  output logic [DES_BLOCK_W-1:0] o_core_cleartext,
  output logic [DES_KEY_W-1:0]   o_core_key,
  output logic                   o_core_encrypt,
  output logic                   o_core_dv,
  input  logic [DES_BLOCK_W-1:0] i_core_ciphertext,
  input  logic                   i_core_dv,
  output logic                   o_rsp0_valid,
  output logic [DES_BLOCK_W-1:0] o_rsp0_data,
  output logic                   o_rsp1_valid,
  output logic [DES_BLOCK_W-1:0] o_rsp1_data,
`ifdef DES_ARB_CHECK_EN
  output logic                   o_err,
`endif
  output logic [$clog2(CORE_LATENCY+1)-1:0] o_inflight
);

  localparam int IW = $clog2(CORE_LATENCY + 1);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         drain_q, drain_d;
  req_tag_t              last_q, last_d;
  logic [DES_BLOCK_W-1:0] ct_q, ct_d;
  logic [DES_KEY_W-1:0]  key_q, key_d;
  logic                  enc_q, enc_d;
  logic                  dv_q, dv_d;
  logic                  rsp0_v_q, rsp0_v_d;
  logic                  rsp1_v_q, rsp1_v_d;
  logic [DES_BLOCK_W-1:0] rsp0_q, rsp0_d;
  logic [DES_BLOCK_W-1:0] rsp1_q, rsp1_d;

  logic     run;
  logic     win0, win1;
  logic     xfer, pop;
  logic     full, empty;
  req_tag_t gnt, pop_tag;

  des_tag_fifo #(
    .DEPTH(CORE_LATENCY)
  ) u_tag_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (xfer),
    .i_push_tag(gnt),
    .i_pop     (pop),
    .o_pop_tag (pop_tag),
    .o_full    (full),
    .o_empty   (empty),
    .o_count   (o_inflight)
  );

  always_comb begin
    run          = (state_q == ST_RUN);
    win0         = i_req0_valid & (~i_req1_valid | last_q);
    win1         = i_req1_valid & (~i_req0_valid | ~last_q);
    o_req0_ready = run & ~full & win0;
    o_req1_ready = run & ~full & win1;
    xfer         = o_req0_ready | o_req1_ready;
    gnt          = o_req1_ready;
    // Stale core output while draining and orphan results are both dropped.
    pop          = run & i_core_dv & ~empty;
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (!run) begin
      if (drain_q == IW'(CORE_LATENCY)) begin
        state_d = ST_RUN;
      end else begin
        drain_d = drain_q + 1'b1;
      end
    end
  end

  always_comb begin
    last_d   = last_q;
    ct_d     = ct_q;
    key_d    = key_q;
    enc_d    = enc_q;
    dv_d     = xfer;
    if (xfer) begin
      last_d = gnt;
      ct_d   = gnt ? i_req1_data : i_req0_data;
      key_d  = gnt ? i_req1_key : i_req0_key;
      enc_d  = gnt ? i_req1_encrypt : i_req0_encrypt;
    end
    rsp0_v_d = pop & ~pop_tag;
    rsp1_v_d = pop & pop_tag;
    rsp0_d   = rsp0_v_d ? i_core_ciphertext : rsp0_q;
    rsp1_d   = rsp1_v_d ? i_core_ciphertext : rsp1_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_DRAIN;
      drain_q  <= '0;
      last_q   <= 1'b1;
      ct_q     <= '0;
      key_q    <= '0;
      enc_q    <= 1'b0;
      dv_q     <= 1'b0;
      rsp0_v_q <= 1'b0;
      rsp1_v_q <= 1'b0;
      rsp0_q   <= '0;
      rsp1_q   <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      last_q   <= last_d;
      ct_q     <= ct_d;
      key_q    <= key_d;
      enc_q    <= enc_d;
      dv_q     <= dv_d;
      rsp0_v_q <= rsp0_v_d;
      rsp1_v_q <= rsp1_v_d;
      rsp0_q   <= rsp0_d;
      rsp1_q   <= rsp1_d;
    end
  end

  assign o_core_cleartext = ct_q;
  assign o_core_key       = key_q;
  assign o_core_encrypt   = enc_q;
  assign o_core_dv        = dv_q;
  assign o_rsp0_valid     = rsp0_v_q;
  assign o_rsp1_valid     = rsp1_v_q;
  assign o_rsp0_data      = rsp0_q;
  assign o_rsp1_data      = rsp1_q;

`ifdef DES_ARB_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q
          | (run & i_core_dv & empty)
          | (run & full & (i_req0_valid | i_req1_valid));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`endif

endmodule
